// File: rtl/addr8u_serial_inverse.sv
// addr8u_serial_inverse: bit-serial recovery of B = S - A with range flag and re-add self-check
module addr8u_serial_inverse #(
   parameter int WIDTH    = 8,
   parameter bit CHECK_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   sum_i,
   input  logic [WIDTH-1:0] a_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] b_o,
   output logic             range_err_o,
   output logic             fault_o,
   output logic             busy_o
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, SUB, CHECK, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] s_sr, a_sr, b_sr, b_nxt;
   logic [WIDTH:0] chk_sum;
   logic [CW-1:0] cnt;
   logic s_msb, brw, brw_nxt, d, rng, rng_nxt, last;
   assign d       = s_sr[0] ^ a_sr[0] ^ brw;
   assign brw_nxt = (~s_sr[0] & a_sr[0]) | (~(s_sr[0] ^ a_sr[0]) & brw);
   assign b_nxt   = {d, b_sr[WIDTH-1:1]};
   // a final borrow without a set S MSB is underflow; a set MSB without borrow is over-range
   assign rng_nxt = s_msb ^ brw_nxt;
   assign last    = cnt == CW'(WIDTH - 1);
   assign chk_sum = {1'b0, a_sr} + {1'b0, b_sr};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  state_nxt = in_valid ? SUB : IDLE;
         SUB:   state_nxt = last ? (CHECK_EN ? CHECK : DONE) : SUB;
         CHECK: state_nxt = DONE;
         DONE:  state_nxt = out_ready ? IDLE : DONE;
      endcase
   end
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
      busy_o    = state != IDLE;
   end
   // S and A rotate rather than shift so both are intact again for the re-add check
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s_sr        <= '0;
         a_sr        <= '0;
         b_sr        <= '0;
         s_msb       <= 1'b0;
         brw         <= 1'b0;
         rng         <= 1'b0;
         cnt         <= '0;
         b_o         <= '0;
         range_err_o <= 1'b0;
         fault_o     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               s_sr  <= sum_i[WIDTH-1:0];
               s_msb <= sum_i[WIDTH];
               a_sr  <= a_i;
               b_sr  <= '0;
               brw   <= 1'b0;
               cnt   <= '0;
            end
            SUB: begin
               s_sr <= {s_sr[0], s_sr[WIDTH-1:1]};
               a_sr <= {a_sr[0], a_sr[WIDTH-1:1]};
               b_sr <= b_nxt;
               brw  <= brw_nxt;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  rng <= rng_nxt;
                  if (!CHECK_EN) begin
                     b_o         <= b_nxt;
                     range_err_o <= rng_nxt;
                     fault_o     <= 1'b0;
                  end
               end
            end
            CHECK: begin
               b_o         <= b_sr;
               range_err_o <= rng;
               fault_o     <= CHECK_EN && (chk_sum != {s_msb, s_sr}) && !rng;
            end
            DONE: ;
         endcase
      end
endmodule
